// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared across the MIPS pipeline slice.
//   - ALU operation codes (ALUOperation encoding)
//   - Forward-select codes reported by the EX-stage operand muxes
//   - Default datapath widths
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned SHAMT_W    = 5;

    typedef enum logic [3:0] {
        ALU_AND    = 4'b0000,
        ALU_OR     = 4'b0001,
        ALU_NOR    = 4'b0010,
        ALU_ADD    = 4'b0011,
        ALU_SUB    = 4'b0100,
        ALU_SHIFTR = 4'b1100,
        ALU_SHIFTL = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/alu_operand_stage_forward_mux.sv
// forward_mux: compare-and-select for one EX-stage source operand.
// Picks the newest in-flight value for src_reg: EX/MEM first, then MEM/WB,
// otherwise the value captured from the register file. Register 0 is never
// forwarded.
// Ports:
//   src_reg          source register number held in ID/EX
//   reg_value        operand value held in ID/EX
//   exmem_*          EX/MEM write-back candidate (enable, dest, value)
//   memwb_*          MEM/WB write-back candidate (enable, dest, value)
//   fwd_value        selected operand
//   fwd_sel          which source was selected
module forward_mux
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src_reg,
    input  logic [DATA_W-1:0] reg_value,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_write_reg,
    input  logic [DATA_W-1:0] exmem_value,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_write_reg,
    input  logic [DATA_W-1:0] memwb_value,
    output logic [DATA_W-1:0] fwd_value,
    output fwd_sel_e          fwd_sel
);

    always_comb begin
        fwd_value = reg_value;
        fwd_sel   = FWD_REG;
        if (exmem_reg_write && (exmem_write_reg != '0) && (exmem_write_reg == src_reg)) begin
            fwd_value = exmem_value;
            fwd_sel   = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_write_reg != '0) && (memwb_write_reg == src_reg)) begin
            fwd_value = memwb_value;
            fwd_sel   = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX pipeline register plus EX-stage operand forwarding,
// feeding the ALU's ALUOperation, A, B and shamt inputs.
// Build option: define ALU_OPERAND_FORWARD_EN to enable the capture-time
// MEM/WB bypass and the EX forwarding muxes. Without it operands come straight
// from the pipeline register, fwd_a/fwd_b read 0, and the hazard unit stalls.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   stall, flush       hold / bubble the ID/EX register (flush wins)
//   id_*               decoded instruction fields from ID
//   exmem_*, memwb_*   in-flight register writes used for forwarding
//   ex_*               registered/forwarded fields driving EX and the ALU
//   fwd_a, fwd_b       forward select in use for rs / rt
module alu_operand_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned OP_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_alu_op,
    input  logic [DATA_W-1:0]  id_read_data1,
    input  logic [DATA_W-1:0]  id_read_data2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_alu_src,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_write_reg,
    input  logic               id_reg_write,
    input  logic               exmem_reg_write,
    input  logic [REG_AW-1:0]  exmem_write_reg,
    input  logic [DATA_W-1:0]  exmem_alu_result,
    input  logic               memwb_reg_write,
    input  logic [REG_AW-1:0]  memwb_write_reg,
    input  logic [DATA_W-1:0]  memwb_write_data,
    output logic               ex_valid,
    output logic [OP_W-1:0]    ex_alu_op,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [SHAMT_W-1:0] ex_shamt,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic [REG_AW-1:0]  ex_write_reg,
    output logic               ex_reg_write,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);

    logic               valid_q,     valid_d;
    logic [OP_W-1:0]    alu_op_q,    alu_op_d;
    logic [DATA_W-1:0]  rs_val_q,    rs_val_d;
    logic [DATA_W-1:0]  rt_val_q,    rt_val_d;
    logic [DATA_W-1:0]  imm_q,       imm_d;
    logic               alu_src_q,   alu_src_d;
    logic [SHAMT_W-1:0] shamt_q,     shamt_d;
    logic [REG_AW-1:0]  rs_q,        rs_d;
    logic [REG_AW-1:0]  rt_q,        rt_d;
    logic [REG_AW-1:0]  write_reg_q, write_reg_d;
    logic               reg_write_q, reg_write_d;

    logic [DATA_W-1:0]  rs_cap, rt_cap;
    logic [DATA_W-1:0]  a_fwd, b_fwd;

    // Capture-time bypass: the register file is written on the same edge that
    // ID/EX captures, so a MEM/WB write to a source register must be taken
    // directly or ID/EX would latch the stale read.
    always_comb begin
        rs_cap = id_read_data1;
        rt_cap = id_read_data2;
`ifdef ALU_OPERAND_FORWARD_EN
        if (memwb_reg_write && (memwb_write_reg != '0) && (memwb_write_reg == id_rs)) begin
            rs_cap = memwb_write_data;
        end
        if (memwb_reg_write && (memwb_write_reg != '0) && (memwb_write_reg == id_rt)) begin
            rt_cap = memwb_write_data;
        end
`endif
    end

    always_comb begin
        valid_d     = valid_q;
        alu_op_d    = alu_op_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        imm_d       = imm_q;
        alu_src_d   = alu_src_q;
        shamt_d     = shamt_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        write_reg_d = write_reg_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            // Bubble: every field zeroed, so rs/rt=0 also disables forwarding.
            valid_d     = 1'b0;
            alu_op_d    = '0;
            rs_val_d    = '0;
            rt_val_d    = '0;
            imm_d       = '0;
            alu_src_d   = 1'b0;
            shamt_d     = '0;
            rs_d        = '0;
            rt_d        = '0;
            write_reg_d = '0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            valid_d     = id_valid;
            alu_op_d    = id_alu_op;
            rs_val_d    = rs_cap;
            rt_val_d    = rt_cap;
            imm_d       = id_imm;
            alu_src_d   = id_alu_src;
            shamt_d     = id_shamt;
            rs_d        = id_rs;
            rt_d        = id_rt;
            write_reg_d = id_write_reg;
            reg_write_d = id_reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            alu_op_q    <= '0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            shamt_q     <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            write_reg_q <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alu_op_q    <= alu_op_d;
            rs_val_q    <= rs_val_d;
            rt_val_q    <= rt_val_d;
            imm_q       <= imm_d;
            alu_src_q   <= alu_src_d;
            shamt_q     <= shamt_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            write_reg_q <= write_reg_d;
            reg_write_q <= reg_write_d;
        end
    end

`ifdef ALU_OPERAND_FORWARD_EN
    fwd_sel_e fwd_a_sel, fwd_b_sel;

    forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_reg         (rs_q),
        .reg_value       (rs_val_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_write_reg (exmem_write_reg),
        .exmem_value     (exmem_alu_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_write_reg (memwb_write_reg),
        .memwb_value     (memwb_write_data),
        .fwd_value       (a_fwd),
        .fwd_sel         (fwd_a_sel)
    );

    forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_reg         (rt_q),
        .reg_value       (rt_val_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_write_reg (exmem_write_reg),
        .exmem_value     (exmem_alu_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_write_reg (memwb_write_reg),
        .memwb_value     (memwb_write_data),
        .fwd_value       (b_fwd),
        .fwd_sel         (fwd_b_sel)
    );

    assign fwd_a = fwd_a_sel;
    assign fwd_b = fwd_b_sel;
`else
    // Forwarding inputs and registered rs/rt have no consumer in this build.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs_q, rt_q, exmem_reg_write, exmem_write_reg,
                                 exmem_alu_result, memwb_reg_write,
                                 memwb_write_reg, memwb_write_data};
    assign a_fwd = rs_val_q;
    assign b_fwd = rt_val_q;
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    assign ex_valid      = valid_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_a          = a_fwd;
    assign ex_store_data = b_fwd;
    assign ex_b          = alu_src_q ? imm_q : b_fwd;
    assign ex_shamt      = shamt_q;
    assign ex_write_reg  = write_reg_q;
    assign ex_reg_write  = valid_q & reg_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid;
    logic [3:0]  id_alu_op;
    logic [31:0] id_read_data1, id_read_data2, id_imm;
    logic        id_alu_src;
    logic [4:0]  id_shamt, id_rs, id_rt, id_write_reg;
    logic        id_reg_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_write_reg;
    logic [31:0] exmem_alu_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_write_reg;
    logic [31:0] memwb_write_data;
    logic        ex_valid;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_shamt, ex_write_reg;
    logic        ex_reg_write;
    logic [1:0]  fwd_a, fwd_b;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(32), .REG_AW(5), .OP_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .id_valid         (id_valid),
        .id_alu_op        (id_alu_op),
        .id_read_data1    (id_read_data1),
        .id_read_data2    (id_read_data2),
        .id_imm           (id_imm),
        .id_alu_src       (id_alu_src),
        .id_shamt         (id_shamt),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_write_reg     (id_write_reg),
        .id_reg_write     (id_reg_write),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_write_reg  (exmem_write_reg),
        .exmem_alu_result (exmem_alu_result),
        .memwb_reg_write  (memwb_reg_write),
        .memwb_write_reg  (memwb_write_reg),
        .memwb_write_data (memwb_write_data),
        .ex_valid         (ex_valid),
        .ex_alu_op        (ex_alu_op),
        .ex_a             (ex_a),
        .ex_b             (ex_b),
        .ex_shamt         (ex_shamt),
        .ex_store_data    (ex_store_data),
        .ex_write_reg     (ex_write_reg),
        .ex_reg_write     (ex_reg_write),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b)
    );

    // Reference: the instruction currently occupying the EX slot.
    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        src;
        logic [4:0]  shamt, rs, rt, wr;
        logic        rw;
    } slot_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] a, b, sd;
        logic [4:0]  shamt, wr;
        logic        rw;
        logic [1:0]  fa, fb;
    } exp_t;

    slot_t slot;
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;

    // Value a register read yields at capture, honouring a write-back in the same cycle.
    function automatic logic [31:0] read_at_capture(input logic [4:0] r, input logic [31:0] rf_val);
`ifdef ALU_OPERAND_FORWARD_EN
        if (memwb_reg_write && r != 5'd0 && memwb_write_reg == r) return memwb_write_data;
`endif
        return rf_val;
    endfunction

    // Newest value of register r given what is in flight right now.
    task automatic newest(input logic [4:0] r, input logic [31:0] held,
                          output logic [31:0] val, output logic [1:0] sel);
        val = held;
        sel = 2'd0;
`ifdef ALU_OPERAND_FORWARD_EN
        if (r != 5'd0) begin
            if (exmem_reg_write && exmem_write_reg == r) begin
                val = exmem_alu_result;
                sel = 2'd2;
            end else if (memwb_reg_write && memwb_write_reg == r) begin
                val = memwb_write_data;
                sel = 2'd1;
            end
        end
`endif
    endtask

    task automatic slot_update();
        if (reset || flush) begin
            slot = '0;
        end else if (!stall) begin
            slot.valid = id_valid;
            slot.op    = id_alu_op;
            slot.a     = read_at_capture(id_rs, id_read_data1);
            slot.b     = read_at_capture(id_rt, id_read_data2);
            slot.imm   = id_imm;
            slot.src   = id_alu_src;
            slot.shamt = id_shamt;
            slot.rs    = id_rs;
            slot.rt    = id_rt;
            slot.wr    = id_write_reg;
            slot.rw    = id_reg_write;
        end
    endtask

    task automatic push_expect();
        exp_t        e;
        logic [31:0] av, bv;
        logic [1:0]  as, bs;
        newest(slot.rs, slot.a, av, as);
        newest(slot.rt, slot.b, bv, bs);
        e.valid = slot.valid;
        e.op    = slot.op;
        e.a     = av;
        e.sd    = bv;
        e.b     = slot.src ? slot.imm : bv;
        e.shamt = slot.shamt;
        e.wr    = slot.wr;
        e.rw    = slot.valid && slot.rw;
        e.fa    = as;
        e.fb    = bs;
        sb.push_back(e);
    endtask

    // Record what the current inputs should produce this cycle, then clock.
    task automatic step();
        push_expect();
        @(posedge clk);
        slot_update();
        #1;
    endtask

    task automatic rand_id();
        id_valid      = 1'($urandom_range(0, 1));
        id_alu_op     = 4'($urandom);
        id_read_data1 = $urandom;
        id_read_data2 = $urandom;
        id_imm        = $urandom;
        id_alu_src    = 1'($urandom_range(0, 1));
        id_shamt      = 5'($urandom);
        id_rs         = 5'($urandom_range(0, 7));
        id_rt         = 5'($urandom_range(0, 7));
        id_write_reg  = 5'($urandom_range(0, 7));
        id_reg_write  = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_fwd();
        exmem_reg_write  = 1'($urandom_range(0, 1));
        exmem_write_reg  = 5'($urandom_range(0, 7));
        exmem_alu_result = $urandom;
        memwb_reg_write  = 1'($urandom_range(0, 1));
        memwb_write_reg  = 5'($urandom_range(0, 7));
        memwb_write_data = $urandom;
    endtask

    task automatic idle_fwd();
        rand_fwd();
        exmem_reg_write = 1'b0;
        memwb_reg_write = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected record per cycle and compares every output.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ex_valid",      32'(ex_valid),      32'(e.valid));
            chk("ex_alu_op",     32'(ex_alu_op),     32'(e.op));
            chk("ex_a",          ex_a,               e.a);
            chk("ex_b",          ex_b,               e.b);
            chk("ex_store_data", ex_store_data,      e.sd);
            chk("ex_shamt",      32'(ex_shamt),      32'(e.shamt));
            chk("ex_write_reg",  32'(ex_write_reg),  32'(e.wr));
            chk("ex_reg_write",  32'(ex_reg_write),  32'(e.rw));
            chk("fwd_a",         32'(fwd_a),         32'(e.fa));
            chk("fwd_b",         32'(fwd_b),         32'(e.fb));
        end
    end

    initial begin
        slot  = '0;
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        rand_id();
        id_valid = 1'b1;
        rand_fwd();
        @(posedge clk);
        slot_update();
        #1;

        // Reset held a second cycle with live-looking decode and forwarding inputs.
        rand_id();
        id_valid = 1'b1;
        rand_fwd();
        step();

        // Release: this edge loads the first instruction.
        reset = 1'b0;
        rand_id();
        id_valid = 1'b1;
        idle_fwd();
        step();

        // EX/MEM hazard on rs=8.
        rand_id();
        id_valid = 1'b1;
        id_rs = 5'd8;
        id_read_data1 = 32'h0000_0011;
        idle_fwd();
        step();
        rand_id();
        idle_fwd();
        exmem_reg_write  = 1'b1;
        exmem_write_reg  = 5'd8;
        exmem_alu_result = 32'h0000_0055;
        step();

        // Double hazard on rt=9, register operand then immediate operand.
        for (int k = 0; k < 2; k++) begin
            rand_id();
            id_valid   = 1'b1;
            id_rs      = 5'd3;
            id_rt      = 5'd9;
            id_alu_src = (k == 1);
            id_imm     = 32'hFFFF_FFFC;
            idle_fwd();
            step();
            rand_id();
            exmem_reg_write  = 1'b1;
            exmem_write_reg  = 5'd9;
            exmem_alu_result = 32'h0000_00AA;
            memwb_reg_write  = 1'b1;
            memwb_write_reg  = 5'd9;
            memwb_write_data = 32'h0000_00BB;
            step();
        end

        // r0 is never forwarded or bypassed.
        rand_id();
        id_valid = 1'b1;
        id_rs = 5'd0;
        id_rt = 5'd0;
        id_read_data1 = 32'h0;
        id_read_data2 = 32'h0;
        id_alu_src = 1'b0;
        idle_fwd();
        memwb_reg_write = 1'b1;
        memwb_write_reg = 5'd0;
        step();
        rand_id();
        exmem_reg_write  = 1'b1;
        exmem_write_reg  = 5'd0;
        exmem_alu_result = 32'h0000_1234;
        memwb_reg_write  = 1'b1;
        memwb_write_reg  = 5'd0;
        step();

        // Stall for three cycles while ID keeps changing, then flush on top of stall.
        rand_id();
        id_valid = 1'b1;
        id_reg_write = 1'b1;
        idle_fwd();
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_id();
            rand_fwd();
            step();
        end
        flush = 1'b1;
        rand_id();
        id_valid = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        rand_id();
        rand_fwd();
        step();

        // Capture bypass: r5 written back on the same edge rs=5 is captured.
        rand_id();
        id_valid = 1'b1;
        id_rs = 5'd5;
        id_read_data1 = 32'h0;
        idle_fwd();
        memwb_reg_write  = 1'b1;
        memwb_write_reg  = 5'd5;
        memwb_write_data = 32'hDEAD_BEEF;
        step();
        rand_id();
        idle_fwd();
        step();

        // Randomized traffic with occasional stall, flush and reset.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rand_id();
            rand_fwd();
            step();
        end

        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        rand_id();
        idle_fwd();
        step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS pipeline. Sits directly upstream of the ALU and drives its ALUOperation, A, B and shamt inputs.
- Captures decoded operands each cycle and honours stall/flush from the hazard unit.
- Resolves RAW hazards by selecting the newest value from EX/MEM, MEM/WB or the register file.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register-address width (register 0 is hard-wired zero)
- OP_W, 4, ALU operation code width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- stall  in  1  hold ID/EX contents
- flush  in  1  replace ID/EX contents with bubble
- id_valid  in  1  decode holds a real instruction
- id_alu_op  in  OP_W  ALU operation code
- id_read_data1  in  DATA_W  register-file rs value
- id_read_data2  in  DATA_W  register-file rt value
- id_imm  in  DATA_W  sign-extended immediate
- id_alu_src  in  1  1 = B takes immediate
- id_shamt  in  5  shift amount
- id_rs, id_rt, id_write_reg  in  REG_AW  source and destination register numbers
- id_reg_write  in  1  instruction writes a register
- exmem_reg_write  in  1  EX/MEM will write
- exmem_write_reg  in  REG_AW  EX/MEM destination
- exmem_alu_result  in  DATA_W  EX/MEM value
- memwb_reg_write  in  1  MEM/WB will write
- memwb_write_reg  in  REG_AW  MEM/WB destination
- memwb_write_data  in  DATA_W  MEM/WB value
- ex_valid  out  1  EX slot holds real instruction
- ex_alu_op  out  OP_W  to ALU ALUOperation
- ex_a  out  DATA_W  to ALU A
- ex_b  out  DATA_W  to ALU B
- ex_shamt  out  5  to ALU shamt
- ex_store_data  out  DATA_W  forwarded rt value, for sw
- ex_write_reg  out  REG_AW  destination register
- ex_reg_write  out  1  gated by ex_valid
- fwd_a, fwd_b  out  2  forward select in use: 0 = reg, 1 = MEM/WB, 2 = EX/MEM

Behaviour:
- Reset: all registered fields are 0, giving ex_valid=0, ex_reg_write=0, ex_alu_op=4'b0000, ex_a=ex_b=ex_store_data=0, fwd_a=fwd_b=0.
- Capture latency: 1 cycle. On each rising edge with no stall/flush, all id_* fields are loaded.
- Write-first bypass at capture: if memwb_reg_write && memwb_write_reg!=0 && memwb_write_reg==id_rs, rs is captured from memwb_write_data instead of id_read_data1. The same rule applies to rt.
- Priority: reset > flush > stall > load.
  - Flush clears valid, reg_write, write_reg and alu_op to 0. Data fields are don't-care but are driven to 0.
  - Stall holds every field unchanged.
- EX forwarding is combinational (zero latency), computed from the registered rs/rt.
  - Select EX/MEM when exmem_reg_write && exmem_write_reg!=0 && match.
  - Otherwise select MEM/WB under the same conditions.
  - Otherwise use the registered value.
  - EX/MEM always wins over MEM/WB.
- ex_a = forwarded rs.
- ex_store_data = forwarded rt.
- ex_b = registered imm when alu_src=1, otherwise forwarded rt. fwd_b reports the rt select even when alu_src=1.
- Forwarding is evaluated even when ex_valid=0; downstream gating uses ex_valid and ex_reg_write.
- Register 0 is never forwarded and never bypassed; a read of r0 always yields the register-file value.

Optional Feature:
- Macro ALU_OPERAND_FORWARD_EN.
  - Defined: forwarding and capture bypass as above.
  - Undefined: both paths are removed. ex_a/ex_b/ex_store_data come straight from the registered values, fwd_a=fwd_b=0 constant, and the hazard unit must stall instead.

Decomposition:
- Shared package mips_pkg holds:
  - ALU op codes: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, SHIFTR 1100, SHIFTL 1110
  - Forward select codes FWD_REG/FWD_MEMWB/FWD_EXMEM
  - DATA_W/REG_AW defaults
- One sub-module, forward_mux: one operand's compare-and-select. It is instantiated twice (rs, rt) and compiled out when the macro is absent.

Test Plan:
- Reset held 2 cycles with id_valid=1 → all outputs 0. First edge after release loads id_*; ex_valid=1 one cycle later.
- EX/MEM hazard: id_rs=8, exmem_reg_write=1, exmem_write_reg=8, exmem_alu_result=0x0000_0055, read_data1=0x11 → ex_a=0x55, fwd_a=2.
- Double hazard: rt=9 matched by both EX/MEM (0xAA) and MEM/WB (0xBB), alu_src=0 → ex_b=0xAA, fwd_b=2. With alu_src=1 and imm=0xFFFF_FFFC → ex_b=0xFFFF_FFFC and ex_store_data=0xAA.
- r0 guard: id_rs=0, exmem_write_reg=0, exmem_reg_write=1, result=0x1234 → ex_a=0, fwd_a=0.
- Stall 3 cycles while id_* changes → ex_* unchanged. Flush asserted together with stall → next cycle ex_valid=0, ex_reg_write=0.
- Capture bypass: memwb writes r5=0xDEAD_BEEF in the same cycle id_rs=5 and read_data1=0 is captured → ex_a=0xDEAD_BEEF on the following cycle, with no other forwarding active.
